// File: rtl/mux_nto1_scan_if.sv
// Bus bundle for the N:1 scanning mux: channel data and controls in, selection out.
// Latency: none (wires only).
// Backpressure: none; the consumer takes every output cycle.
interface mux_nto1_scan_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] A;
  logic [SEL_W-1:0]          S;
  logic                      EN;
  logic                      MODE;
  logic [WIDTH-1:0]          Y;
  logic                      VALID;
  logic [SEL_W-1:0]          CH;
  logic                      WRAP;
  logic                      ERR;

  // Source/consumer side: drives channels and controls, observes the selection.
  modport master (output A, S, EN, MODE, input Y, VALID, CH, WRAP, ERR);
  // Mux side.
  modport slave  (input A, S, EN, MODE, output Y, VALID, CH, WRAP, ERR);
endinterface

// File: rtl/mux_nto1_scan.sv
// Registered N:1 mux with manual select or auto-scan (each channel held DWELL cycles).
// Latency: 1 cycle from input sample to Y/VALID/CH/WRAP/ERR.
// Backpressure: none; a new selection is presented every enabled cycle.
module mux_nto1_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 1,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic            clk,
  input  logic            rst,
  mux_nto1_scan_if.slave  bus
);

  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [DCNT_W-1:0]   dcnt_cur;
  logic [WIDTH-1:0]    y_q;
  logic                vld_q;
  logic [SEL_W-1:0]    ch_q;
  logic                wrap_q;
  logic                err_q;

  logic [WIDTH-1:0]    man_dat;
  logic [WIDTH-1:0]    scan_dat;
  logic                s_ok;
  logic                dwell_last;
  logic                ptr_last;

  // Next state, channel decode for both selectors, and dwell bookkeeping.
  always_comb begin
    state_d  = IDLE;
    man_dat  = '0;
    scan_dat = '0;
    s_ok     = 1'b0;
    if (bus.EN) state_d = bus.MODE ? SCAN : MANUAL;
    // Explicit compare loop keeps an out-of-range S from slicing past A.
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.S == SEL_W'(k)) begin
        man_dat = bus.A[k*WIDTH +: WIDTH];
        s_ok    = 1'b1;
      end
      if (ptr_q == SEL_W'(k)) scan_dat = bus.A[k*WIDTH +: WIDTH];
    end
    // A fresh entry into SCAN gives the current channel a full dwell.
    dcnt_cur   = (state_q == SCAN) ? dcnt_q : '0;
    dwell_last = (dcnt_cur == DCNT_W'(DWELL - 1));
    ptr_last   = (ptr_q == SEL_W'(CHANNELS - 1));
  end

  // FSM with registered outputs; ptr/dcnt only move while scanning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_d)
        MANUAL: begin
          ch_q   <= bus.S;
          wrap_q <= 1'b0;
          y_q    <= s_ok ? man_dat : '0;
          vld_q  <= s_ok;
          err_q  <= !s_ok;
        end
        SCAN: begin
          y_q    <= scan_dat;
          ch_q   <= ptr_q;
          vld_q  <= 1'b1;
          err_q  <= 1'b0;
          wrap_q <= dwell_last && ptr_last;
          if (dwell_last) begin
            dcnt_q <= '0;
            ptr_q  <= ptr_last ? '0 : ptr_q + SEL_W'(1);
          end else begin
            dcnt_q <= dcnt_cur + DCNT_W'(1);
          end
        end
        default: begin
          vld_q  <= 1'b0;
          wrap_q <= 1'b0;
          err_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Y     = y_q;
  assign bus.VALID = vld_q;
  assign bus.CH    = ch_q;
  assign bus.WRAP  = wrap_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
module tb_mux_nto1_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_nto1_scan_if #(.WIDTH(8), .CHANNELS(8)) bus8 ();
  mux_nto1_scan_if #(.WIDTH(8), .CHANNELS(6)) bus6 ();

  mux_nto1_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  mux_nto1_scan #(.WIDTH(8), .CHANNELS(6), .DWELL(1)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  typedef struct packed {
    logic [7:0] y;
    logic       vld;
    logic [2:0] ch;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];

  // Reference model state, one slot per DUT (0: 8 ch / dwell 2, 1: 6 ch / dwell 1).
  logic [7:0] m_y[2];
  logic [2:0] m_ch[2];
  int         m_ptr[2];
  int         m_dcnt[2];
  bit         m_scan[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_y[d] = 8'h00; m_ch[d] = 3'd0; m_ptr[d] = 0; m_dcnt[d] = 0; m_scan[d] = 1'b0;
    end
  endtask

  function automatic logic [7:0] chan(input int d, input int k);
    if (d == 0) return bus8.A[k*8 +: 8];
    return bus6.A[k*8 +: 8];
  endfunction

  task automatic model(input int d, input int nch, input int dw, input logic [2:0] s,
                       input logic en, input logic mode, output exp_t e);
    int dc;
    e = '0;
    if (!en) begin
      e.y = m_y[d]; e.ch = m_ch[d];
      m_scan[d] = 1'b0;
    end else if (!mode) begin
      e.ch = s;
      if (int'(s) < nch) begin e.y = chan(d, int'(s)); e.vld = 1'b1; end
      else begin e.y = 8'h00; e.err = 1'b1; end
      m_scan[d] = 1'b0;
    end else begin
      dc = m_scan[d] ? m_dcnt[d] : 0;
      e.y = chan(d, m_ptr[d]); e.ch = 3'(m_ptr[d]); e.vld = 1'b1;
      e.wrap = (m_ptr[d] == nch - 1) && (dc == dw - 1);
      if (dc == dw - 1) begin dc = 0; m_ptr[d] = (m_ptr[d] + 1) % nch; end
      else dc = dc + 1;
      m_dcnt[d] = dc;
      m_scan[d] = 1'b1;
    end
    m_y[d] = e.y; m_ch[d] = e.ch;
  endtask

  task automatic cmp(input string tag, input exp_t obs, input exp_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed y=%h vld=%b ch=%0d wrap=%b err=%b, expected y=%h vld=%b ch=%0d wrap=%b err=%b",
             tag, obs.y, obs.vld, obs.ch, obs.wrap, obs.err, exp.y, exp.vld, exp.ch, exp.wrap, exp.err);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push expectations for the current inputs, clock once, then pop and compare.
  task automatic step();
    exp_t e8, e6, o;
    model(0, 8, 2, bus8.S, bus8.EN, bus8.MODE, e8); q8.push_back(e8);
    model(1, 6, 1, bus6.S, bus6.EN, bus6.MODE, e6); q6.push_back(e6);
    @(posedge clk); #1;
    o = {bus8.Y, bus8.VALID, bus8.CH, bus8.WRAP, bus8.ERR};
    if (q8.size() == 0) chk("sb8_empty", 32'd0, 32'd1); else cmp("sb8", o, q8.pop_front());
    o = {bus6.Y, bus6.VALID, bus6.CH, bus6.WRAP, bus6.ERR};
    if (q6.size() == 0) chk("sb6_empty", 32'd0, 32'd1); else cmp("sb6", o, q6.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wraps;
    for (int k = 0; k < 8; k++) bus8.A[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 6; k++) bus6.A[k*8 +: 8] = 8'h30 + 8'(k);
    bus8.S = 3'd0; bus8.EN = 1'b0; bus8.MODE = 1'b0;
    bus6.S = 3'd0; bus6.EN = 1'b0; bus6.MODE = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst0_y", 32'(bus8.Y), 32'h0);
    chk("rst0_vld", 32'(bus8.VALID), 32'h0);

    // Manual decode sweep.
    bus8.EN = 1'b1;
    for (int s = 0; s < 8; s++) begin
      bus8.S = 3'(s);
      step();
      chk("man_y", 32'(bus8.Y), 32'h10 + s);
      chk("man_ch", 32'(bus8.CH), 32'(s));
    end

    // Scan a little, then assert reset between edges and look before any edge.
    bus8.MODE = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("arst_y", 32'(bus8.Y), 32'h0);
    chk("arst_vld", 32'(bus8.VALID), 32'h0);
    chk("arst_ch", 32'(bus8.CH), 32'h0);
    chk("arst_wrap", 32'(bus8.WRAP), 32'h0);
    chk("arst_err", 32'(bus8.ERR), 32'h0);
    rst = 1'b0;
    model_reset();

    // Two full scan periods from reset: 10,10,11,11,...,17,17 with WRAP on the second 17.
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("scan_y", 32'(bus8.Y), 32'h10 + (i % 16) / 2);
      chk("scan_wrap", 32'(bus8.WRAP), 32'((i % 16) == 15));
      if (bus8.WRAP) wraps++;
    end
    chk("wrap_cnt8", 32'(wraps), 32'd2);

    // Advance to the first dwell cycle of channel 3.
    repeat (7) step();
    chk("p4_first", 32'(bus8.Y), 32'h13);

    // Pause: VALID drops, Y holds.
    bus8.EN = 1'b0;
    repeat (3) begin
      step();
      chk("pause_vld", 32'(bus8.VALID), 32'h0);
      chk("pause_y", 32'(bus8.Y), 32'h13);
    end
    bus8.EN = 1'b1;
    step(); chk("resume_a", 32'(bus8.Y), 32'h13);
    step(); chk("resume_b", 32'(bus8.Y), 32'h13);
    step(); chk("resume_c", 32'(bus8.Y), 32'h14);
    step(); step();
    chk("at5", 32'(bus8.Y), 32'h15);

    // Mode switch to manual and back.
    bus8.MODE = 1'b0; bus8.S = 3'd2;
    step();
    chk("sw_y", 32'(bus8.Y), 32'h12);
    chk("sw_ch", 32'(bus8.CH), 32'd2);
    bus8.MODE = 1'b1;
    step(); chk("back_a", 32'(bus8.Y), 32'h15);
    step(); chk("back_b", 32'(bus8.Y), 32'h15);
    step(); chk("back_c", 32'(bus8.Y), 32'h16);

    // Six channels: out-of-range select, then in range, then scan with dwell 1.
    bus8.EN = 1'b0;
    bus6.EN = 1'b1; bus6.MODE = 1'b0; bus6.S = 3'd6;
    repeat (3) begin
      step();
      chk("oor_y", 32'(bus6.Y), 32'h0);
      chk("oor_vld", 32'(bus6.VALID), 32'h0);
      chk("oor_err", 32'(bus6.ERR), 32'h1);
    end
    bus6.S = 3'd7;
    step();
    chk("oor7_err", 32'(bus6.ERR), 32'h1);
    bus6.S = 3'd5;
    step();
    chk("in5_y", 32'(bus6.Y), 32'h35);
    chk("in5_vld", 32'(bus6.VALID), 32'h1);
    chk("in5_err", 32'(bus6.ERR), 32'h0);
    bus6.MODE = 1'b1;
    wraps = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      chk("scan6_y", 32'(bus6.Y), 32'h30 + (i % 6));
      chk("scan6_wrap", 32'(bus6.WRAP), 32'((i % 6) == 5));
      if (bus6.WRAP) wraps++;
    end
    chk("wrap_cnt6", 32'(wraps), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
Parametrised, registered N:1 multiplexer. It generalises the fixed 8:1 single-bit mux to CHANNELS inputs of WIDTH bits each. Two modes:
- Manual: the external select S chooses the channel.
- Auto-scan: an internal pointer steps through every channel, holding each one for DWELL cycles.
It sits between multi-channel sources and a single-channel consumer, and emits VALID, the current channel number and a wrap pulse.

Parameters:
WIDTH, 1, bits per channel (≥1)
CHANNELS, 8, number of input channels (≥2, need not be a power of 2)
DWELL, 1, cycles each channel is held in scan mode (≥1)
SEL_W, $clog2(CHANNELS), select/pointer width; derived, must not be overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
A  input  CHANNELS*WIDTH  packed channel data; channel k = A[k*WIDTH +: WIDTH]
S  input  SEL_W  manual channel select
EN  input  1  block enable
MODE  input  1  0 = manual, 1 = auto-scan
Y  output  WIDTH  registered selected data
VALID  output  1  Y holds a valid selection
CH  output  SEL_W  channel index that produced the current Y
WRAP  output  1  one-cycle pulse on the last dwell cycle of channel CHANNELS-1 in scan mode
ERR  output  1  one-cycle pulse: manual S out of range

Behaviour:
- One clock; reset is asynchronous and active-high. On rst, immediately and regardless of clk: Y=0, VALID=0, CH=0, WRAP=0, ERR=0, state=IDLE, ptr=0, dwell counter dcnt=0.
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge n appear on the outputs after edge n.
- State register values: IDLE, MANUAL, SCAN.
- Next state, evaluated at each edge:
  - !EN -> IDLE
  - EN & !MODE -> MANUAL
  - EN & MODE -> SCAN
- IDLE (entered with !EN):
  - VALID<=0, WRAP<=0, ERR<=0.
  - Y and CH hold their last values.
  - ptr and dcnt hold.
- MANUAL (EN & !MODE):
  - S<CHANNELS: Y<=A[S], CH<=S, VALID<=1, ERR<=0.
  - S≥CHANNELS (only possible when CHANNELS is not a power of 2): Y<=0, CH<=S, VALID<=0, ERR<=1. ERR repeats every cycle S stays out of range.
  - WRAP<=0. ptr and dcnt hold.
- SCAN (EN & MODE):
  - Y<=A[ptr], CH<=ptr, VALID<=1, ERR<=0.
  - Entering SCAN from IDLE or MANUAL: dcnt restarts at 0, so the current ptr gets a full DWELL cycles. ptr is not reloaded; scanning resumes where it stopped.
  - When dcnt==DWELL-1: dcnt<=0 and ptr<=(ptr==CHANNELS-1)?0:ptr+1. Otherwise dcnt<=dcnt+1.
  - WRAP<=1 exactly when the registered output is for ptr==CHANNELS-1 with dcnt==DWELL-1; otherwise 0.
  - DWELL=1: ptr advances every cycle and each channel appears for exactly one cycle.
- S is ignored in SCAN. A changes are visible on the next edge in either mode; there is no extra buffering.
- MODE change while EN=1 takes effect at the next edge (no dead cycle):
  - SCAN->MANUAL freezes ptr and dcnt.
  - MANUAL->SCAN resumes from the frozen ptr with dcnt=0.
- Scan period is CHANNELS*DWELL cycles. WRAP therefore pulses once per period.
- rst asserted mid-scan forces ptr=0. The first scan after reset outputs channel 0.
- X/Z on S in MANUAL is not supported. The bench drives only defined values.

Test Plan:
1. CHANNELS=8, WIDTH=8. rst pulse -> Y=0, VALID=0, CH=0, WRAP=0, ERR=0 immediately, before any clk edge.
2. Manual decode: A[k]=8'h10+k, MODE=0, EN=1, sweep S=0..7 one per cycle -> one cycle later Y=8'h10..8'h17, CH=S, VALID=1, ERR=0.
3. Scan: DWELL=2, MODE=1, EN=1, start from reset -> Y sequence 10,10,11,11,…,17,17,10. WRAP=1 only on the second 17 cycle, i.e. every 16 cycles.
4. Pause/resume: during scan at ptr=3 (first dwell cycle), drop EN for 3 cycles ->
   - VALID=0 and Y holds 8'h13.
   - After EN returns, Y=8'h13 for 2 cycles, then 8'h14.
5. Mode switch: scanning at ptr=5, switch to MODE=0 with S=2 -> next cycle Y=8'h12, CH=2. Back to MODE=1 -> Y=8'h15 for 2 cycles.
6. CHANNELS=6, MODE=0, S=3'd6 -> Y=0, VALID=0, ERR=1 each cycle held. Then S=3'd5 -> Y=A[5], VALID=1, ERR=0. In scan mode with DWELL=1, ptr wraps 5->0 and WRAP pulses every 6 cycles.
